// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the posted-write store buffer.
package store_buffer_pkg;
    localparam int unsigned SB_DEPTH  = 4;
    localparam int unsigned SB_ADDR_W = 32;
    localparam int unsigned SB_DATA_W = 32;
    localparam int unsigned WADDR_W   = SB_ADDR_W - 2;

    typedef struct packed {
        logic                 valid;
        logic [WADDR_W-1:0]   waddr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/sb_match.sv
// Word-address comparator across all buffer entries with youngest-match priority.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t            entries [DEPTH],
    input  logic [PTR_W-1:0]     head,
    input  logic [PTR_W-1:0]     tail,
    input  logic [WADDR_W-1:0]   waddr,
    output logic                 anyHit,
    output logic                 hitNonHead,
    output logic [PTR_W-1:0]     hitIdx,
    output logic [SB_DATA_W-1:0] hitData
);
    logic [PTR_W-1:0] idx;

    // Walking from tail upward visits free slots first, then valid entries
    // oldest to youngest, so the last match found is the youngest.
    always_comb begin
        anyHit  = 1'b0;
        hitIdx  = '0;
        hitData = '0;
        idx     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = tail + PTR_W'(k);
            if (entries[idx].valid && entries[idx].waddr == waddr) begin
                anyHit  = 1'b1;
                hitIdx  = idx;
                hitData = entries[idx].data;
            end
        end
        hitNonHead = anyHit && (hitIdx != head);
    end
endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between MEM stage and data memory, with store coalescing
// and youngest-entry load forwarding.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memWrite,
    input  logic                     memRead,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W-1:0]        writeData,
    output logic [DATA_W-1:0]        readData,
    output logic                     loadHit,
    output logic                     stall,
    output logic                     memReq,
    output logic [ADDR_W-1:0]        memAddr,
    output logic [DATA_W-1:0]        memWData,
    input  logic                     memAck,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   cnt;

    logic              anyHit;
    logic              hitNonHead;
    logic [PTR_W-1:0]  hitIdx;
    logic [DATA_W-1:0] hitData;

    logic full;
    logic coalesce;
    logic enq;
    logic deq;

    sb_match #(.DEPTH(DEPTH)) u_match (
        .entries    (entries),
        .head       (head),
        .tail       (tail),
        .waddr      (address[ADDR_W-1:2]),
        .anyHit     (anyHit),
        .hitNonHead (hitNonHead),
        .hitIdx     (hitIdx),
        .hitData    (hitData)
    );

    // The head may be in flight, so only younger entries absorb a store.
    always_comb begin
        full     = (cnt == (PTR_W+1)'(DEPTH));
        coalesce = memWrite && hitNonHead;
        enq      = memWrite && !coalesce && !full;
        stall    = memWrite && full && !coalesce;
        memReq   = (cnt != '0);
        deq      = memReq && memAck;
        loadHit  = memRead && !memWrite && anyHit;
        readData = loadHit ? hitData : '0;
        memAddr  = memReq ? {entries[head].waddr, 2'b00} : '0;
        memWData = memReq ? entries[head].data : '0;
        count    = cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entries <= '{default: '0};
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
        end else begin
            if (coalesce)
                entries[hitIdx].data <= writeData;
            if (enq)
                entries[tail] <= '{valid: 1'b1, waddr: address[ADDR_W-1:2], data: writeData};
            if (deq)
                entries[head].valid <= 1'b0;
            if (enq)
                tail <= tail + 1'b1;
            if (deq)
                head <= head + 1'b1;
            case ({enq, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based model.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        memWrite, memRead, memAck;
    logic [31:0] address, writeData;
    logic [31:0] readData, memAddr, memWData;
    logic        loadHit, stall, memReq;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .memWrite  (memWrite),
        .memRead   (memRead),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .loadHit   (loadHit),
        .stall     (stall),
        .memReq    (memReq),
        .memAddr   (memAddr),
        .memWData  (memWData),
        .memAck    (memAck),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One pipeline cycle: drive inputs, check outputs against the model,
    // then apply the model's update at the clock edge.
    task automatic cycle(input logic mw, input logic mr, input logic [31:0] a,
                         input logic [31:0] d, input logic ack);
        int ci, hi, sz;
        logic exp_stall, exp_hit, exp_enq;
        logic [31:0] exp_rd;
        memWrite = mw; memRead = mr; address = a; writeData = d; memAck = ack;
        sz = q.size();
        ci = -1;
        for (int i = 1; i < sz; i++) if (q[i].w == a[31:2]) ci = i;
        hi = -1;
        for (int i = 0; i < sz; i++) if (q[i].w == a[31:2]) hi = i;
        exp_stall = mw && ci < 0 && sz == 4;
        exp_enq   = mw && ci < 0 && sz < 4;
        exp_hit   = mr && !mw && hi >= 0;
        exp_rd    = exp_hit ? q[hi].d : 32'h0;
        #3;
        chk("stall", {31'b0, stall}, {31'b0, exp_stall});
        chk("loadHit", {31'b0, loadHit}, {31'b0, exp_hit});
        chk("readData", readData, exp_rd);
        chk("memReq", {31'b0, memReq}, (sz != 0) ? 32'd1 : 32'd0);
        chk("count", {29'b0, count}, sz);
        chk("memAddr", memAddr, (sz != 0) ? {q[0].w, 2'b00} : 32'h0);
        chk("memWData", memWData, (sz != 0) ? q[0].d : 32'h0);
        @(posedge clk);
        if (mw && ci >= 0) q[ci].d = d;
        if (sz != 0 && ack) void'(q.pop_front());
        if (exp_enq) q.push_back('{w: a[31:2], d: d});
        #1;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic ack);
        cycle(1'b1, 1'b0, a, d, ack);
    endtask

    task automatic lw(input logic [31:0] a, input logic ack);
        cycle(1'b0, 1'b1, a, $urandom, ack);
    endtask

    task automatic idle(input logic ack);
        cycle(1'b0, 1'b0, $urandom, $urandom, ack);
    endtask

    initial begin
        reset = 1'b1; memWrite = 0; memRead = 0; memAck = 0; address = 0; writeData = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_memReq", {31'b0, memReq}, 32'd0);
        chk("rst_count", {29'b0, count}, 32'd0);
        reset = 1'b0;

        // post / retire
        sw(32'h10, 32'hAABBCCDD, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // fill, stall, drain one, coalesce while full
        sw(32'h0, 32'h1, 1'b0); sw(32'h4, 32'h2, 1'b0);
        sw(32'h8, 32'h3, 1'b0); sw(32'hC, 32'h4, 1'b0);
        sw(32'h20, 32'h5, 1'b0);
        sw(32'h4, 32'h55, 1'b0);
        sw(32'h20, 32'h5, 1'b1);
        sw(32'h20, 32'h5, 1'b0);
        repeat (6) idle(1'b1);

        // forwarding past an in-flight head
        sw(32'h8, 32'h11, 1'b0);
        sw(32'h8, 32'h22, 1'b0);
        lw(32'h8, 1'b0); lw(32'h9, 1'b0); lw(32'h40, 1'b0);
        cycle(1'b1, 1'b1, 32'h8, 32'h33, 1'b0);
        lw(32'hB, 1'b0);
        repeat (4) idle(1'b1);

        // back-to-back with ack held high
        for (int i = 0; i < 10; i++) sw(32'(i * 4), $urandom, 1'b1);
        idle(1'b1);

        // random traffic with varying backpressure
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [31:0] a;
            logic ack;
            r   = $urandom_range(0, 9);
            a   = ($urandom_range(0, 5) << 2) | $urandom_range(0, 3);
            ack = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (r < 4)      sw(a, $urandom, ack);
            else if (r < 8) lw(a, ack);
            else            idle(ack);
        end
        repeat (6) idle(1'b1);

        // asynchronous reset between edges with pending stores
        sw(32'h100, 32'hA, 1'b0); sw(32'h104, 32'hB, 1'b0); sw(32'h108, 32'hC, 1'b0);
        memWrite = 0; memRead = 1; address = 32'h104; memAck = 0;
        #2;
        chk("pre_rst_loadHit", {31'b0, loadHit}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_memReq", {31'b0, memReq}, 32'd0);
        chk("arst_count", {29'b0, count}, 32'd0);
        chk("arst_stall", {31'b0, stall}, 32'd0);
        chk("arst_loadHit", {31'b0, loadHit}, 32'd0);
        chk("arst_readData", readData, 32'd0);
        chk("arst_memAddr", memAddr, 32'd0);
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        lw(32'h104, 1'b0);
        lw(32'h100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Word-granular posted-write buffer between the MEM stage and the backing data memory. Stores from the MEM stage are queued in a small FIFO and retired to memory over a req/ack write port, so a slow memory only stalls the pipeline when the buffer is full. Loads that hit a buffered address are forwarded from the youngest matching entry. On a miss, the top level uses the existing combinational memory read.

## Interface
- DEPTH, 4, number of entries (power of two, ≥2)
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- memWrite  in  1  MEM-stage store strobe (sw)
- memRead  in  1  MEM-stage load strobe (lw)
- address  in  ADDR_W  MEM-stage byte address
- writeData  in  DATA_W  store data
- readData  out  DATA_W  forwarded load data; 0 when loadHit=0
- loadHit  out  1  load matched a buffered entry
- stall  out  1  hold PC/IFID/IDEX/EXMEM/MEMWB this cycle
- memReq  out  1  head entry valid, write pending
- memAddr  out  ADDR_W  head entry address
- memWData  out  DATA_W  head entry data
- memAck  in  1  backing memory accepted head this cycle
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage: circular FIFO. Each entry holds valid, addr[ADDR_W-1:2] and data. Uses head/tail pointers and a count register.
- Address compare uses address[ADDR_W-1:2] only; the low 2 bits are ignored. memAddr is driven with low bits 00.
- Store, coalesce case: memWrite=1 and the address matches a valid entry other than the head → that entry's data is overwritten, with no enqueue and no stall (even when full).
- Store, enqueue case: otherwise, if count<DEPTH, write at tail, tail+1 (wraps modulo DEPTH), count+1.
- Store, full case: otherwise stall=1 and nothing is written. The MEM stage re-presents the same store next cycle.
- A store matching only the head (which may be in flight) is enqueued as a new entry. The head is never modified while memReq=1.
- stall = memWrite & full & ~coalesce. It is combinational and does not depend on memAck; no same-cycle pass-through.
- Drain: memReq = (count≠0). memAddr/memWData show the head entry.
  - When memReq & memAck at a clock edge: head+1, count−1.
  - memAck while memReq=0 is ignored.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance.
- Load: memRead=1 → compare against all valid entries.
  - Any match → loadHit=1 and readData = data of the youngest match (nearest to tail). At most two matches can exist (head + one coalesced).
  - No match → loadHit=0, readData=0.
- memRead and memWrite are never both asserted. If they are, the store takes priority and loadHit=0.
- Reset (asynchronous, any time): all valid bits clear, pointers=0, count=0. Pending stores are discarded. Outputs go to memReq=0, stall=0, loadHit=0, readData=0, memAddr=0, memWData=0, count=0.

## Timing
- Enqueue takes effect at the clock edge. The entry is visible to load forwarding and to memReq from the next cycle.
- The earliest memAck for a store is 1 cycle after its MEM cycle. With memAck tied high, each store retires in 1 cycle.
- Coalesced data is visible to forwarding and (if the entry later becomes head) to memWData the next cycle.
- memAddr/memWData are stable while memReq=1 and memAck=0.
- Load forwarding is combinational in the same cycle as memRead.

## Structure
- Shared package store_buffer_pkg: DEPTH default, word-address width constant (ADDR_W−2), entry struct {valid, waddr, data}.
- One sub-module, sb_match: combinational comparator plus youngest-first priority select. Inputs are the entry array, head pointer, tail pointer and compare address. Outputs are anyHit, hitNonHead, hitIdx and hitData. It is used for both coalescing and forwarding.
- Top instantiates store_buffer between EXMEM outputs and dataMemory. It ORs stall into the existing hazard stall and muxes readData over the memory read on loadHit.

## Test plan
- Basic post/retire: memAck=0, sw 0x10←0xAABBCCDD → next cycle memReq=1, memAddr=0x10, memWData=0xAABBCCDD, count=1. Raise memAck for 1 cycle → count=0, memReq=0.
- Fill/stall: memAck=0, 4 stores to 0x0,0x4,0x8,0xC → count=4. 5th store to 0x20 → stall=1 and count stays 4. memAck 1 cycle → stall drops, 0x20 enqueued the following cycle, count=4.
- Coalesce: buffer {0x0,0x4}, memAck=0, sw 0x4←0x55 while full or not → no stall, count unchanged. Later drain shows memWData=0x55 for 0x4.
- Forwarding: buffer head 0x8←0x11 (in flight), then sw 0x8←0x22 (new entry). lw 0x8 → loadHit=1, readData=0x22. lw 0x9 (same word) → 0x22. lw 0x40 → loadHit=0, readData=0.
- Wrap-around and simultaneous ops: memAck held high, 10 back-to-back stores → count never exceeds 1, pointers wrap. Retired addresses come out in issue order.
- Async reset mid-drain: count=3, memReq=1, assert reset between clock edges → memReq, count, stall and loadHit go to 0 immediately. After release, lw of a previously buffered address → loadHit=0.
